apu_unit_arbiter: RTL and testbench
===================================

# apu_unit_arbiter

Round-robin arbiter that shares one fixed-latency, fully pipelined APU unit (FP addsub, mult, MAC, cast, div, sqrt or DSP) between NB_CORES requesting cores. It grants at most one request per cycle and muxes the winner's operands into the unit. It tags each issued operation with the core index in a shift register matched to the unit's pipeline depth, and routes the unit result back as a single-cycle valid pulse to the originating core. One instance sits in front of each shared unit in the APU cluster; private-unit configurations bypass it.

## Interface
- NB_CORES, 4, number of requesting cores (≥2)
- PIPE_REGS, 1, unit latency in cycles (C_*_PIPE_REGS of the served unit); must be ≥1, elaboration error otherwise
- WIDTH, 32, operand/result width (FP_WIDTH)
- WOP, 1, opcode width (WOP_* of the served unit)
- NARGS, 2, operands per op (1..3)
- NDSFLAGS, 3, downstream flag width (NDSFLAGS_*)
- NUSFLAGS, 8, upstream flag width (NUSFLAGS_*)
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- core_req_i  in  NB_CORES  per-core request
- core_gnt_o  out  NB_CORES  one-hot grant, combinational from core_req_i and priority pointer
- core_op_i  in  NB_CORES×WOP  per-core opcode
- core_args_i  in  NB_CORES×NARGS×WIDTH  per-core operands
- core_flags_i  in  NB_CORES×NDSFLAGS  per-core downstream flags (rounding mode etc.)
- core_rvalid_o  out  NB_CORES  one-cycle result-valid pulse to the tagged core
- core_result_o  out  WIDTH  result, broadcast to all cores
- core_flags_o  out  NUSFLAGS  status flags, broadcast
- unit_valid_o  out  1  operation issued this cycle
- unit_op_o / unit_args_o / unit_flags_o  out  WOP / NARGS×WIDTH / NDSFLAGS  muxed from granted core
- unit_result_i / unit_flags_i  in  WIDTH / NUSFLAGS  unit output, PIPE_REGS cycles after issue

## Operation
- Each cycle: if any core_req_i set, grant exactly one core; grant = first requester at or after priority pointer `prio_q`, searching upward with wrap from NB_CORES-1 to 0.
- Request/grant is a same-cycle handshake: transfer occurs when req && gnt; core holds req and operands until granted. A request without a grant has no effect.
- On a grant to core k: unit_valid_o=1, unit_* = core k fields, `prio_q` ← (k+1) mod NB_CORES next cycle. With no request: unit_valid_o=0, unit_* driven from core 0 (don't-care), `prio_q` unchanged.
- Tag pipeline: PIPE_REGS stages of {valid, core index [$clog2(NB_CORES)-1:0]}; stage 0 loads {unit_valid_o, granted index}, then shifts every cycle without stall.
- Output: core_rvalid_o = onehot(tag index) & last-stage valid; core_result_o/core_flags_o = unit_result_i/unit_flags_i passthrough.
- Unit never stalls and cores always accept results: no backpressure path exists.
- Reset (any time, async): `prio_q`←0, all tag valids←0; in-flight operations are discarded and never produce rvalid. While rst_ni=0, core_gnt_o=0, unit_valid_o=0 and core_rvalid_o=0.

## Timing
- Issue to core_rvalid_o: exactly PIPE_REGS cycles (issue in cycle t → rvalid in t+PIPE_REGS).
- Throughput: one op/cycle aggregate; a single core with no competition may issue every cycle.
- Fairness: with all cores requesting continuously, each core is granted once every NB_CORES cycles.
- A core may have up to PIPE_REGS ops in flight; results return in issue order.
- Simultaneous events: a result returning to core k and a new grant to core k in the same cycle are independent and both valid.

## Structure
- apu_cluster_package holds NB_CORES, the C_*_PIPE_REGS latencies and the WOP_/NDSFLAGS_/NUSFLAGS_ constants used to parameterize each instance; no new typedefs are required.
- Sub-module: apu_rr_arbiter, a combinational round-robin priority encoder: inputs req and prio pointer, outputs one-hot gnt and binary index.
- Top level contains only the `prio_q` register, the operand mux and the tag shift register.

## Test plan
- Single request: NB_CORES=4, PIPE_REGS=1, core 2 requests once with args 0x3F800000, 0x40000000 → gnt[2] same cycle; unit_args match; one cycle later core_rvalid_o=4'b0100 with unit_result_i (0x40400000 from a model adder).
- Full contention: all 4 cores request for 8 cycles from reset → grant order 0,1,2,3,0,1,2,3; each rvalid pulse arrives 1 cycle after its grant.
- Deep pipe: PIPE_REGS=5, core 1 issues 3 back-to-back ops, then core 3 issues 1 → rvalid 0010 in cycles t+5..t+7 and 1000 in t+8, with results in issue order.
- Pointer wrap/skip: prio_q=3, requests only on cores 1 and 2 → core 1 granted, prio_q→2; next cycle core 2 granted.
- Reset mid-flight: PIPE_REGS=3, two ops in flight, pulse rst_ni low for 1 cycle → no rvalid ever appears for them; gnt=0 during reset; first post-reset grant goes to the lowest requesting index.
- Idle: no requests for 10 cycles → unit_valid_o=0 and core_rvalid_o=0 throughout, prio_q unchanged.

Source files
------------

// File: rtl/apu_unit_arbiter_pkg.sv
// Shared constants for APU cluster arbiter instances and the round-robin
// pointer helper used by apu_unit_arbiter.
package apu_unit_arbiter_pkg;

  localparam int unsigned NB_CORES             = 32'd4;
  localparam int unsigned FP_WIDTH             = 32'd32;
  localparam int unsigned C_FPU_ADDSUB_PIPE_REGS = 32'd1;
  localparam int unsigned C_FPU_MULT_PIPE_REGS = 32'd1;
  localparam int unsigned C_FPU_MAC_PIPE_REGS  = 32'd2;
  localparam int unsigned C_FPU_CAST_PIPE_REGS = 32'd1;
  localparam int unsigned C_FPU_DIV_PIPE_REGS  = 32'd3;
  localparam int unsigned C_FPU_SQRT_PIPE_REGS = 32'd5;
  localparam int unsigned WOP_FPU              = 32'd1;
  localparam int unsigned NDSFLAGS_FPU         = 32'd3;
  localparam int unsigned NUSFLAGS_FPU         = 32'd8;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1) % n;
  endfunction

endpackage

// File: rtl/apu_unit_arbiter_if.sv
// Core-side request/result bus and unit-side issue/return bus of one shared
// APU unit. master = cores plus unit, slave = arbiter.
interface apu_unit_arbiter_if #(
  parameter int unsigned NB_CORES = 32'd4,
  parameter int unsigned WIDTH    = 32'd32,
  parameter int unsigned WOP      = 32'd1,
  parameter int unsigned NARGS    = 32'd2,
  parameter int unsigned NDSFLAGS = 32'd3,
  parameter int unsigned NUSFLAGS = 32'd8
);
  logic [NB_CORES-1:0]                        core_req;
  logic [NB_CORES-1:0]                        core_gnt;
  logic [NB_CORES-1:0][WOP-1:0]               core_op;
  logic [NB_CORES-1:0][NARGS-1:0][WIDTH-1:0]  core_args;
  logic [NB_CORES-1:0][NDSFLAGS-1:0]          core_flags;
  logic [NB_CORES-1:0]                        core_rvalid;
  logic [WIDTH-1:0]                           core_result;
  logic [NUSFLAGS-1:0]                        core_rflags;
  logic                                       unit_valid;
  logic [WOP-1:0]                             unit_op;
  logic [NARGS-1:0][WIDTH-1:0]                unit_args;
  logic [NDSFLAGS-1:0]                        unit_flags;
  logic [WIDTH-1:0]                           unit_result;
  logic [NUSFLAGS-1:0]                        unit_rflags;

  modport master (
    output core_req, core_op, core_args, core_flags, unit_result, unit_rflags,
    input  core_gnt, core_rvalid, core_result, core_rflags,
           unit_valid, unit_op, unit_args, unit_flags
  );

  modport slave (
    input  core_req, core_op, core_args, core_flags, unit_result, unit_rflags,
    output core_gnt, core_rvalid, core_result, core_rflags,
           unit_valid, unit_op, unit_args, unit_flags
  );

endinterface

// File: rtl/apu_unit_arbiter_rr.sv
// Combinational round-robin priority encoder: first requester at or above the
// pointer, wrapping from N-1 back to 0. Outputs one-hot grant and its index.
module apu_rr_arbiter #(
  parameter int unsigned N  = 32'd4,
  parameter int unsigned IW = 32'd2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] prio,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          found_s;
  logic          hit_s;
  logic [IW-1:0] pos_s;

  // Walk the rotated request vector once; the first hit wins.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    pos_s   = '0;
    for (int unsigned j = 32'd0; j < N; j++) begin
      pos_s      = IW'((32'(prio) + j) % N);
      hit_s      = req[pos_s] & ~found_s;
      gnt[pos_s] = hit_s;
      idx        = hit_s ? pos_s : idx;
      found_s    = found_s | hit_s;
    end
  end

endmodule

// File: rtl/apu_unit_arbiter.sv
// Round-robin front end of one shared, fixed-latency APU unit: grants one core
// per cycle, muxes its operands, and tags results back to the issuing core.
module apu_unit_arbiter
  import apu_unit_arbiter_pkg::*;
#(
  parameter int unsigned NB_CORES  = 32'd4,
  parameter int unsigned PIPE_REGS = 32'd1
) (
  input  logic clk_i,
  input  logic rst_ni,
  apu_unit_arbiter_if.slave bus
);

  localparam int unsigned IW = (NB_CORES > 32'd1) ? $clog2(NB_CORES) : 32'd1;

  if (PIPE_REGS < 32'd1) begin : g_bad_pipe
    $error("apu_unit_arbiter: PIPE_REGS must be at least 1");
  end

  logic [NB_CORES-1:0]  gnt_s;
  logic [IW-1:0]        idx_s;
  logic                 valid_s;
  logic [IW-1:0]        prio_r;
  logic [PIPE_REGS-1:0] tag_v_r;
  logic [IW-1:0]        tag_idx_r [PIPE_REGS];

  function automatic logic [NB_CORES-1:0] onehot(input logic [IW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  apu_rr_arbiter #(
    .N  (NB_CORES),
    .IW (IW)
  ) u_rr (
    .req  (bus.core_req),
    .prio (prio_r),
    .gnt  (gnt_s),
    .idx  (idx_s)
  );

  // Grants are suppressed while reset is held so nothing can issue.
  assign valid_s        = rst_ni & (|bus.core_req);
  assign bus.core_gnt   = gnt_s & {NB_CORES{rst_ni}};
  assign bus.unit_valid = valid_s;
  assign bus.unit_op    = bus.core_op[idx_s];
  assign bus.unit_args  = bus.core_args[idx_s];
  assign bus.unit_flags = bus.core_flags[idx_s];

  assign bus.core_rvalid = tag_v_r[PIPE_REGS-1] ? onehot(tag_idx_r[PIPE_REGS-1]) : '0;
  assign bus.core_result = bus.unit_result;
  assign bus.core_rflags = bus.unit_rflags;

  // Priority pointer moves just past the winner; it holds when nobody asks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_r <= '0;
    end else if (valid_s) begin
      prio_r <= IW'(rr_next(32'(idx_s), NB_CORES));
    end else begin
      prio_r <= prio_r;
    end
  end

  // Tag shift register mirrors the unit pipeline; it never stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_v_r <= '0;
      for (int unsigned i = 32'd0; i < PIPE_REGS; i++) begin
        tag_idx_r[i] <= '0;
      end
    end else begin
      tag_v_r[0]   <= valid_s;
      tag_idx_r[0] <= idx_s;
      for (int unsigned i = 32'd1; i < PIPE_REGS; i++) begin
        tag_v_r[i]   <= tag_v_r[i-1];
        tag_idx_r[i] <= tag_idx_r[i-1];
      end
    end
  end

endmodule

// File: tb/tb_apu_unit_arbiter.sv
// Bench for apu_unit_arbiter: three instances (latency 1, 3, 5) share one
// stimulus; a cycle-indexed issue log predicts grants and result routing.
module tb_apu_unit_arbiter;

  localparam int NB = 4;
  localparam int HN = 256;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic [NB-1:0]             req = '0;
  logic [NB-1:0]             op = '0;
  logic [NB-1:0][1:0][31:0]  args = '0;
  logic [NB-1:0][2:0]        fl = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // issue log: per cycle, was an op issued, by whom, and what the unit returns
  logic        hist_v   [HN];
  int          hist_c   [HN];
  logic [31:0] hist_res [HN];
  int          ptr_m = 0;
  int          win;
  logic [NB-1:0] exp_gnt;

  apu_unit_arbiter_if #(.NB_CORES(NB)) if1 ();
  apu_unit_arbiter_if #(.NB_CORES(NB)) if3 ();
  apu_unit_arbiter_if #(.NB_CORES(NB)) if5 ();

  apu_unit_arbiter #(.NB_CORES(NB), .PIPE_REGS(1)) u1 (.clk_i(clk), .rst_ni(rst_ni), .bus(if1.slave));
  apu_unit_arbiter #(.NB_CORES(NB), .PIPE_REGS(3)) u3 (.clk_i(clk), .rst_ni(rst_ni), .bus(if3.slave));
  apu_unit_arbiter #(.NB_CORES(NB), .PIPE_REGS(5)) u5 (.clk_i(clk), .rst_ni(rst_ni), .bus(if5.slave));

  assign if1.core_req = req;  assign if1.core_op = op;  assign if1.core_args = args;  assign if1.core_flags = fl;
  assign if3.core_req = req;  assign if3.core_op = op;  assign if3.core_args = args;  assign if3.core_flags = fl;
  assign if5.core_req = req;  assign if5.core_op = op;  assign if5.core_args = args;  assign if5.core_flags = fl;

  // unit model: returns the result of the op issued PIPE_REGS cycles earlier
  assign if1.unit_result = (cyc >= 1) ? hist_res[cyc-1] : 32'd0;
  assign if3.unit_result = (cyc >= 3) ? hist_res[cyc-3] : 32'd0;
  assign if5.unit_result = (cyc >= 5) ? hist_res[cyc-5] : 32'd0;
  assign if1.unit_rflags = if1.unit_result[7:0] ^ 8'hA5;
  assign if3.unit_rflags = if3.unit_result[7:0] ^ 8'hA5;
  assign if5.unit_rflags = if5.unit_result[7:0] ^ 8'hA5;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // single-precision add for normal operands (mantissa truncated)
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    real r;
    logic [63:0] d;
    logic [10:0] e;
    r = f2r(a) + f2r(b);
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic cmp_dut(input int p, input logic [NB-1:0] g, input logic uv, input logic [63:0] ua,
                         input logic uop, input logic [2:0] uf, input logic [NB-1:0] rv,
                         input logic [31:0] res, input logic [7:0] rfl);
    int src;
    logic [NB-1:0] erv;
    string s;
    s = $sformatf("p%0d", p);
    check({s, "_gnt"}, 64'(g), 64'(exp_gnt));
    check({s, "_unit_valid"}, 64'(uv), 64'(win >= 0));
    if (win >= 0) begin
      check({s, "_unit_args"}, ua, args[win]);
      check({s, "_unit_op"}, 64'(uop), 64'(op[win]));
      check({s, "_unit_flags"}, 64'(uf), 64'(fl[win]));
    end
    src = cyc - p;
    erv = (src >= 0 && hist_v[src]) ? (4'b0001 << hist_c[src]) : 4'b0000;
    check({s, "_rvalid"}, 64'(rv), 64'(erv));
    if (erv != 4'b0000) begin
      check({s, "_result"}, 64'(res), 64'(hist_res[src]));
      check({s, "_rflags"}, 64'(rfl), 64'(hist_res[src][7:0] ^ 8'hA5));
    end
  endtask

  // model + compare, once per cycle on the falling edge
  always @(negedge clk) begin
    win = -1;
    exp_gnt = '0;
    if (!rst_ni) begin
      ptr_m = 0;
      for (int i = 0; i < HN; i++) hist_v[i] = 1'b0;
    end else begin
      for (int j = 0; j < NB; j++) begin
        if (win < 0 && req[(ptr_m + j) % NB]) win = (ptr_m + j) % NB;
      end
      if (win >= 0) exp_gnt = 4'b0001 << win;
    end
    cmp_dut(1, if1.core_gnt, if1.unit_valid, if1.unit_args, if1.unit_op, if1.unit_flags,
            if1.core_rvalid, if1.core_result, if1.core_rflags);
    cmp_dut(3, if3.core_gnt, if3.unit_valid, if3.unit_args, if3.unit_op, if3.unit_flags,
            if3.core_rvalid, if3.core_result, if3.core_rflags);
    cmp_dut(5, if5.core_gnt, if5.unit_valid, if5.unit_args, if5.unit_op, if5.unit_flags,
            if5.core_rvalid, if5.core_result, if5.core_rflags);
    if (cyc < HN) begin
      hist_v[cyc]   = (win >= 0);
      hist_c[cyc]   = (win >= 0) ? win : 0;
      hist_res[cyc] = (win >= 0) ? fp_add(args[win][0], args[win][1]) : 32'd0;
    end
    if (win >= 0) ptr_m = (win + 1) % NB;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int k, input logic [31:0] a0, input logic [31:0] a1);
    args[k][0] = a0;
    args[k][1] = a1;
    op[k] = a1[23];
    fl[k] = 3'(k + 1);
  endtask

  initial begin
    for (int i = 0; i < HN; i++) begin
      hist_v[i] = 1'b0; hist_c[i] = 0; hist_res[i] = 32'd0;
    end
    set_core(0, 32'h3F800000, 32'h3F800000);
    set_core(1, 32'h40000000, 32'h3F800000);
    set_core(2, 32'h40400000, 32'h40800000);
    set_core(3, 32'h40800000, 32'h40A00000);
    @(negedge clk);
    check("reset_gnt", 64'(if1.core_gnt), 64'd0);
    check("reset_rvalid", 64'(if5.core_rvalid), 64'd0);
    tick(); tick();
    rst_ni = 1'b1;

    // full contention from reset: 0,1,2,3,0,1,2,3
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("contention_gnt", 64'(if1.core_gnt), 64'(4'b0001 << (i % 4)));
      tick();
    end
    req = 4'b0000;
    tick();

    // single request from core 2: 1.0 + 2.0
    set_core(2, 32'h3F800000, 32'h40000000);
    req = 4'b0100;
    @(negedge clk);
    check("single_gnt", 64'(if1.core_gnt), 64'(4'b0100));
    check("single_args", if1.unit_args, 64'h40000000_3F800000);
    tick();
    req = 4'b0000;
    @(negedge clk);
    check("single_rvalid", 64'(if1.core_rvalid), 64'(4'b0100));
    check("single_result", 64'(if1.core_result), 64'h40400000);
    tick();

    // pointer at 3, requests on 1 and 2
    req = 4'b0110;
    @(negedge clk);
    check("wrap_gnt1", 64'(if1.core_gnt), 64'(4'b0010));
    tick();
    req = 4'b0100;
    @(negedge clk);
    check("wrap_gnt2", 64'(if1.core_gnt), 64'(4'b0100));
    tick();

    // idle: pointer must still be 3 afterwards
    req = 4'b0000;
    repeat (10) tick();
    req = 4'b1001;
    @(negedge clk);
    check("idle_prio_gnt", 64'(if1.core_gnt), 64'(4'b1000));
    tick();
    req = 4'b0000;
    tick();

    // deep pipe: core 1 three ops back to back, then core 3
    set_core(1, 32'h3F800000, 32'h3F800000);
    req = 4'b0010;
    tick();
    set_core(1, 32'h40000000, 32'h40000000);
    tick();
    set_core(1, 32'h40400000, 32'h3F800000);
    tick();
    set_core(3, 32'h40800000, 32'h40800000);
    req = 4'b1000;
    tick();
    req = 4'b0000;
    tick();
    @(negedge clk);
    check("deep_rvalid_t5", 64'(if5.core_rvalid), 64'(4'b0010));
    check("deep_result_t5", 64'(if5.core_result), 64'h40000000);
    tick(); tick(); tick();
    @(negedge clk);
    check("deep_rvalid_t8", 64'(if5.core_rvalid), 64'(4'b1000));
    check("deep_result_t8", 64'(if5.core_result), 64'h41000000);
    tick();

    // reset with two ops in flight in the latency-3 instance
    set_core(0, 32'h40000000, 32'h40400000);
    req = 4'b0001;
    tick();
    tick();
    rst_ni = 1'b0;
    req = 4'b1010;
    @(negedge clk);
    check("rst_gnt", 64'(if3.core_gnt), 64'd0);
    check("rst_unit_valid", 64'(if3.unit_valid), 64'd0);
    check("rst_rvalid", 64'(if3.core_rvalid), 64'd0);
    tick();
    rst_ni = 1'b1;
    @(negedge clk);
    check("post_rst_gnt", 64'(if3.core_gnt), 64'(4'b0010));
    tick();
    req = 4'b1000;
    @(negedge clk);
    check("post_rst_gnt2", 64'(if3.core_gnt), 64'(4'b1000));
    tick();
    req = 4'b0000;
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
